// File: rtl/td4_sequencer.sv
// ---------------------------------------------------------------------------
// td4_sequencer
//
// Purpose:
//   Multi-cycle control unit for the TD4 CPU. It owns the program counter
//   and the carry flag. It walks FETCH -> DECODE -> EXEC on each `tick`
//   clock-enable pulse. In EXEC it emits the register-load strobes, the ALU
//   operand-A source select and the output-port control for the opecode
//   delivered by the instruction decoder.
//
//   The `libcpu` package at the top of this file defines the decoded
//   opecode enumeration that the decoder and this sequencer share.
//
// Parameters:
//   RESET_PC        - pc value after reset.
//   HALT_ON_INVALID - 1: INVALID opecode parks the sequencer in HALT.
//                     0: INVALID behaves exactly like NOP.
//
// Optional feature (macro TD4_SINGLE_STEP_EN):
//   Adds the `step` input and the `stepping` output. After every completed
//   instruction the sequencer waits in PAUSE until it sees a step pulse,
//   then resumes on the next tick.
//
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   tick       in   one-clk clock-enable, qualifies every state transition
//   opecode    in   registered decoder opecode (libcpu::OPECODE)
//   imm        in   registered 4-bit immediate
//   alu_carry  in   carry-out of the 4-bit adder for the current operands
//   step       in   (TD4_SINGLE_STEP_EN only) one-clk single-step request
//   pc         out  instruction ROM address
//   src_sel    out  ALU operand-A source: 0=A, 1=B, 2=IN, 3=zero
//   ld_a       out  one-clk load strobe for register A
//   ld_b       out  one-clk load strobe for register B
//   ld_out     out  one-clk load strobe for the output port register
//   out_imm    out  with ld_out: 1 = output imm, 0 = output B
//   carry      out  carry flag register
//   halted     out  sequencer is parked in HALT
//   instr_done out  one-clk pulse when an instruction completes in EXEC
//   stepping   out  (TD4_SINGLE_STEP_EN only) sequencer waits in PAUSE
// ---------------------------------------------------------------------------

package libcpu;

  // The decoded encodings match the TD4 instruction bits where such bits
  // exist. NOP and INVALID fill two free codes. Any code left unused is
  // treated as INVALID.
  typedef enum logic [3:0] {
    ADD_A_IMM = 4'b0000,
    MOV_A_B   = 4'b0001,
    IN_A      = 4'b0010,
    MOV_A_IMM = 4'b0011,
    MOV_B_A   = 4'b0100,
    ADD_B_IMM = 4'b0101,
    IN_B      = 4'b0110,
    MOV_B_IMM = 4'b0111,
    NOP       = 4'b1000,
    OUT_B     = 4'b1001,
    INVALID   = 4'b1010,
    OUT_IMM   = 4'b1011,
    JNC_IMM   = 4'b1110,
    JMP_IMM   = 4'b1111
  } OPECODE;

endpackage

module td4_sequencer
  import libcpu::*;
#(
  parameter logic [3:0] RESET_PC        = 4'h0,
  parameter bit         HALT_ON_INVALID = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  OPECODE     opecode,
  input  logic [3:0] imm,
  input  logic       alu_carry,
`ifdef TD4_SINGLE_STEP_EN
  input  logic       step,
  output logic       stepping,
`endif
  output logic [3:0] pc,
  output logic [1:0] src_sel,
  output logic       ld_a,
  output logic       ld_b,
  output logic       ld_out,
  output logic       out_imm,
  output logic       carry,
  output logic       halted,
  output logic       instr_done
);

  localparam logic [1:0] SRC_A    = 2'd0;
  localparam logic [1:0] SRC_B    = 2'd1;
  localparam logic [1:0] SRC_IN   = 2'd2;
  localparam logic [1:0] SRC_ZERO = 2'd3;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_HALT   = 3'd3
`ifdef TD4_SINGLE_STEP_EN
    ,
    ST_PAUSE  = 3'd4
`endif
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] pc_q, pc_d;
  logic       carry_q, carry_d;

`ifdef TD4_SINGLE_STEP_EN
  logic       stepPending_q, stepPending_d;
`endif

  logic [1:0] decSrc;
  logic       decLdA;
  logic       decLdB;
  logic       decOut;
  logic       decOutImm;
  logic       decJmp;
  logic       decJnc;
  logic       decInvalid;
  logic       haltNow;

  // Classify the current opecode once. Both the next-state logic and the
  // output logic use these flags. Unused encodings count as INVALID.
  always_comb begin
    decSrc     = SRC_A;
    decLdA     = 1'b0;
    decLdB     = 1'b0;
    decOut     = 1'b0;
    decOutImm  = 1'b0;
    decJmp     = 1'b0;
    decJnc     = 1'b0;
    decInvalid = 1'b0;
    case (opecode)
      ADD_A_IMM: begin decSrc = SRC_A;    decLdA = 1'b1; end
      ADD_B_IMM: begin decSrc = SRC_B;    decLdB = 1'b1; end
      MOV_A_IMM: begin decSrc = SRC_ZERO; decLdA = 1'b1; end
      MOV_B_IMM: begin decSrc = SRC_ZERO; decLdB = 1'b1; end
      MOV_A_B:   begin decSrc = SRC_B;    decLdA = 1'b1; end
      MOV_B_A:   begin decSrc = SRC_A;    decLdB = 1'b1; end
      IN_A:      begin decSrc = SRC_IN;   decLdA = 1'b1; end
      IN_B:      begin decSrc = SRC_IN;   decLdB = 1'b1; end
      OUT_B:     begin decOut = 1'b1; end
      OUT_IMM:   begin decOut = 1'b1; decOutImm = 1'b1; end
      JMP_IMM:   begin decJmp = 1'b1; end
      JNC_IMM:   begin decJnc = 1'b1; end
      NOP:       begin end
      default:   begin decInvalid = 1'b1; end
    endcase
  end

  // An INVALID opecode only diverts into HALT when the parameter asks for
  // it. Otherwise it falls through the NOP path.
  assign haltNow = decInvalid && HALT_ON_INVALID;

  // State register, pc and carry. Reset aborts whatever instruction is in
  // flight because pc and carry change only on the EXEC tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_FETCH;
      pc_q          <= RESET_PC;
      carry_q       <= 1'b0;
`ifdef TD4_SINGLE_STEP_EN
      stepPending_q <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      carry_q       <= carry_d;
`ifdef TD4_SINGLE_STEP_EN
      stepPending_q <= stepPending_d;
`endif
    end
  end

  // Next-state logic. Nothing moves without tick. JNC looks at the carry
  // that is already registered, so the carry update made on the same EXEC
  // tick cannot affect the branch decision.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    carry_d = carry_q;
    if (tick) begin
      case (state_q)
        ST_FETCH:  state_d = ST_DECODE;
        ST_DECODE: state_d = ST_EXEC;
        ST_EXEC: begin
          if (haltNow) begin
            state_d = ST_HALT;
          end else begin
`ifdef TD4_SINGLE_STEP_EN
            state_d = ST_PAUSE;
`else
            state_d = ST_FETCH;
`endif
            carry_d = (decLdA || decLdB) ? alu_carry : 1'b0;
            if (decJmp || (decJnc && !carry_q)) begin
              pc_d = imm;
            end else begin
              pc_d = pc_q + 4'd1;
            end
          end
        end
        ST_HALT:   state_d = ST_HALT;
`ifdef TD4_SINGLE_STEP_EN
        ST_PAUSE: begin
          if (step || stepPending_q) begin
            state_d = ST_FETCH;
          end
        end
`endif
        default:   state_d = ST_FETCH;
      endcase
    end
  end

`ifdef TD4_SINGLE_STEP_EN
  // A step pulse can arrive between ticks. Remember it while paused so
  // the next tick can release the pause. Forget it once PAUSE is left.
  always_comb begin
    stepPending_d = stepPending_q;
    if (state_q == ST_PAUSE && step) begin
      stepPending_d = 1'b1;
    end
    if (state_d != ST_PAUSE) begin
      stepPending_d = 1'b0;
    end
  end

  assign stepping = (state_q == ST_PAUSE);
`endif

  // Output logic. src_sel stays valid for the whole EXEC state so the ALU
  // settles before the tick. The strobes are gated by tick, which makes
  // each of them exactly one clk wide. An instruction that halts emits
  // nothing.
  always_comb begin
    src_sel    = SRC_A;
    ld_a       = 1'b0;
    ld_b       = 1'b0;
    ld_out     = 1'b0;
    out_imm    = 1'b0;
    instr_done = 1'b0;
    if (state_q == ST_EXEC && !haltNow) begin
      src_sel = decSrc;
      if (tick) begin
        ld_a       = decLdA;
        ld_b       = decLdB;
        ld_out     = decOut;
        out_imm    = decOutImm;
        instr_done = 1'b1;
      end
    end
  end

  assign halted = (state_q == ST_HALT);
  assign pc     = pc_q;
  assign carry  = carry_q;

endmodule

// File: tb/tb_td4_sequencer.sv
// ---------------------------------------------------------------------------
// tb_td4_sequencer
//
// Directed bench for td4_sequencer. Two instances share every input.
// dut0 halts on INVALID and dut1 treats INVALID as NOP. Both instances
// reset to pc 4'h3. Inputs change 1 time unit after a rising edge. Outputs
// are read 1 time unit later, away from the edge.
// ---------------------------------------------------------------------------
module tb_td4_sequencer;
  import libcpu::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick;
  OPECODE     opecode;
  logic [3:0] imm;
  logic       alu_carry;

  logic [3:0] pc0, pc1;
  logic [1:0] srcSel0, srcSel1;
  logic       ldA0, ldB0, ldOut0, outImm0, carry0, halted0, instrDone0;
  logic       ldA1, ldB1, ldOut1, outImm1, carry1, halted1, instrDone1;
  logic [4:0] strb0, strb1;

`ifdef TD4_SINGLE_STEP_EN
  logic       step;
  logic       stepping0, stepping1;
`endif

  int checkCount = 0;
  int failCount  = 0;

  typedef struct {
    OPECODE     op;
    logic       ac;
    logic [1:0] src;
    logic [4:0] strb;
    logic       cy;
  } vec_t;

  vec_t vecs [9];

  // Generate the free-running fabric clock.
  always #5 clk = ~clk;

  // Bundle the strobes as {ld_a, ld_b, ld_out, out_imm, instr_done}.
  assign strb0 = {ldA0, ldB0, ldOut0, outImm0, instrDone0};
  assign strb1 = {ldA1, ldB1, ldOut1, outImm1, instrDone1};

  td4_sequencer #(.RESET_PC(4'h3), .HALT_ON_INVALID(1'b1)) dut0 (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick       (tick),
    .opecode    (opecode),
    .imm        (imm),
    .alu_carry  (alu_carry),
`ifdef TD4_SINGLE_STEP_EN
    .step       (step),
    .stepping   (stepping0),
`endif
    .pc         (pc0),
    .src_sel    (srcSel0),
    .ld_a       (ldA0),
    .ld_b       (ldB0),
    .ld_out     (ldOut0),
    .out_imm    (outImm0),
    .carry      (carry0),
    .halted     (halted0),
    .instr_done (instrDone0)
  );

  td4_sequencer #(.RESET_PC(4'h3), .HALT_ON_INVALID(1'b0)) dut1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick       (tick),
    .opecode    (opecode),
    .imm        (imm),
    .alu_carry  (alu_carry),
`ifdef TD4_SINGLE_STEP_EN
    .step       (step),
    .stepping   (stepping1),
`endif
    .pc         (pc1),
    .src_sel    (srcSel1),
    .ld_a       (ldA1),
    .ld_b       (ldB1),
    .ld_out     (ldOut1),
    .out_imm    (outImm1),
    .carry      (carry1),
    .halted     (halted1),
    .instr_done (instrDone1)
  );

  // Count one comparison and report it when observed and expected differ.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drive one set of inputs and let the combinational outputs settle.
  task automatic applyStimulus(input OPECODE op, input logic [3:0] im,
                               input logic t, input logic ac);
    opecode   = op;
    imm       = im;
    tick      = t;
    alu_carry = ac;
    #1;
  endtask

  // Advance to just after the next rising edge.
  task automatic stepClock();
    @(posedge clk);
    #1;
  endtask

`ifdef TD4_SINGLE_STEP_EN
  // Release dut0 from PAUSE. It first waits holdTicks ticks and checks that
  // the pause holds. Then it pulses step between ticks.
  task automatic resumeFromPause(input string tag, input int holdTicks);
    logic [3:0] heldPc;
    heldPc = pc0;
    for (int i = 0; i < holdTicks; i++) begin
      applyStimulus(NOP, 4'h0, 1'b1, 1'b0);
      checkOutput({tag, "/hold"}, 32'({stepping0, pc0, strb0}),
                  32'({1'b1, heldPc, 5'b00000}));
      stepClock();
    end
    applyStimulus(NOP, 4'h0, 1'b0, 1'b0);
    checkOutput({tag, "/paused"}, 32'(stepping0), 1);
    step = 1'b1;
    stepClock();
    step = 1'b0;
    applyStimulus(NOP, 4'h0, 1'b1, 1'b0);
    checkOutput({tag, "/pending"}, 32'(stepping0), 1);
    stepClock();
    checkOutput({tag, "/resumed"}, 32'(stepping0), 0);
  endtask
`endif

  // Run one instruction through FETCH, DECODE and EXEC with tick held high.
  // The task checks pc, src_sel and the strobe bundle of dut0 in each state.
  task automatic runInstr(input string tag, input OPECODE op, input logic [3:0] im,
                          input logic ac, input logic [3:0] expPc,
                          input logic [1:0] expSrc, input logic [4:0] expStrb);
    applyStimulus(op, im, 1'b1, ac);
    checkOutput({tag, "/fetch"}, 32'({pc0, strb0}), 32'({expPc, 5'b00000}));
    stepClock();
    applyStimulus(op, im, 1'b1, ac);
    checkOutput({tag, "/decode"}, 32'({pc0, strb0}), 32'({expPc, 5'b00000}));
    stepClock();
    applyStimulus(op, im, 1'b1, ac);
    checkOutput({tag, "/exec_src"}, 32'(srcSel0), 32'(expSrc));
    checkOutput({tag, "/exec_strb"}, 32'({pc0, strb0}), 32'({expPc, expStrb}));
    stepClock();
`ifdef TD4_SINGLE_STEP_EN
    resumeFromPause(tag, 0);
`endif
  endtask

  initial begin
    logic [3:0] expPc;

    vecs[0] = '{ADD_B_IMM, 1'b1, 2'd1, 5'b01001, 1'b1};
    vecs[1] = '{MOV_A_IMM, 1'b0, 2'd3, 5'b10001, 1'b0};
    vecs[2] = '{MOV_B_IMM, 1'b1, 2'd3, 5'b01001, 1'b1};
    vecs[3] = '{MOV_A_B,   1'b0, 2'd1, 5'b10001, 1'b0};
    vecs[4] = '{MOV_B_A,   1'b1, 2'd0, 5'b01001, 1'b1};
    vecs[5] = '{IN_A,      1'b1, 2'd2, 5'b10001, 1'b1};
    vecs[6] = '{IN_B,      1'b0, 2'd2, 5'b01001, 1'b0};
    vecs[7] = '{ADD_A_IMM, 1'b1, 2'd0, 5'b10001, 1'b1};
    vecs[8] = '{OUT_B,     1'b1, 2'd0, 5'b00101, 1'b0};

    // Hold reset while tick is high so that reset must win.
    rst_n     = 1'b0;
    tick      = 1'b1;
    opecode   = NOP;
    imm       = 4'h0;
    alu_carry = 1'b0;
`ifdef TD4_SINGLE_STEP_EN
    step      = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_pc", 32'(pc0), 32'h3);
    checkOutput("reset_flags", 32'({carry0, halted0, srcSel0, strb0}), 0);
    rst_n = 1'b1;

    // The first instruction has three-tick latency. A reset in EXEC takes
    // its strobe away immediately.
    applyStimulus(ADD_A_IMM, 4'h1, 1'b1, 1'b1);
    stepClock();
    applyStimulus(ADD_A_IMM, 4'h1, 1'b1, 1'b1);
    stepClock();
    applyStimulus(ADD_A_IMM, 4'h1, 1'b1, 1'b1);
    checkOutput("first_exec_strb", 32'(strb0), 32'(5'b10001));
    rst_n = 1'b0;
    #1;
    checkOutput("abort_exec_strb", 32'(strb0), 0);
    rst_n = 1'b1;
    stepClock();
    checkOutput("abort_exec_state", 32'({pc0, carry0}), 32'({4'h3, 1'b0}));

    // The previous edge moved FETCH to DECODE. Reset here must restart the
    // instruction from FETCH and leave pc unchanged.
    rst_n = 1'b0;
    #1;
    checkOutput("rst_decode_pc", 32'({pc0, carry0, strb0}), 32'({4'h3, 6'b0}));
    rst_n = 1'b1;
    runInstr("rst_decode_restart", NOP, 4'h0, 1'b0, 4'h3, 2'd0, 5'b00001);

    // A NOP stream advances pc once per instruction and wraps F to 0.
    expPc = 4'h4;
    for (int i = 0; i < 16; i++) begin
      runInstr("nop_stream", NOP, 4'h0, 1'b0, expPc, 2'd0, 5'b00001);
      expPc = expPc + 4'd1;
    end
    checkOutput("nop_wrap_pc", 32'(pc0), 32'h4);

    // JNC uses the carry left by the previous instruction.
    runInstr("jmp_a", JMP_IMM, 4'hA, 1'b0, 4'h4, 2'd0, 5'b00001);
    runInstr("add_carry", ADD_A_IMM, 4'h1, 1'b1, 4'hA, 2'd0, 5'b10001);
    checkOutput("add_carry_flag", 32'({pc0, carry0}), 32'({4'hB, 1'b1}));
    runInstr("jnc_taken_carry", JNC_IMM, 4'h5, 1'b0, 4'hB, 2'd0, 5'b00001);
    checkOutput("jnc_carry_set", 32'({pc0, carry0}), 32'({4'hC, 1'b0}));
    runInstr("jnc_no_carry", JNC_IMM, 4'h5, 1'b0, 4'hC, 2'd0, 5'b00001);
    checkOutput("jnc_jumps", 32'(pc0), 32'h5);

    // Source select, load strobes and the carry rule for each instruction.
    expPc = 4'h5;
    for (int k = 0; k < 9; k++) begin
      runInstr($sformatf("vec%0d", k), vecs[k].op, 4'h2, vecs[k].ac, expPc,
               vecs[k].src, vecs[k].strb);
      checkOutput($sformatf("vec%0d_carry", k), 32'(carry0), 32'(vecs[k].cy));
      expPc = expPc + 4'd1;
    end

    // With tick only on every 4th clk, OUT_IMM strobes once on the third
    // tick and pc holds until then.
    for (int i = 0; i < 12; i++) begin
      applyStimulus(OUT_IMM, 4'h9, (i % 4) == 3, 1'b0);
      checkOutput($sformatf("gated_clk%0d", i), 32'({pc0, strb0}),
                  32'({4'hE, (i == 11) ? 5'b00111 : 5'b00000}));
      stepClock();
    end
    checkOutput("gated_pc_after", 32'(pc0), 32'hF);
`ifdef TD4_SINGLE_STEP_EN
    resumeFromPause("gated", 0);
`endif

    // Execute INVALID at pc 7 with carry set. dut0 halts. dut1 treats the
    // instruction as NOP.
    runInstr("jmp_6", JMP_IMM, 4'h6, 1'b0, 4'hF, 2'd0, 5'b00001);
    runInstr("set_carry", ADD_A_IMM, 4'h3, 1'b1, 4'h6, 2'd0, 5'b10001);
    applyStimulus(INVALID, 4'h0, 1'b1, 1'b1);
    stepClock();
    applyStimulus(INVALID, 4'h0, 1'b1, 1'b1);
    stepClock();
    applyStimulus(INVALID, 4'h0, 1'b1, 1'b1);
    checkOutput("inv_exec_strb_halt", 32'(strb0), 0);
    checkOutput("inv_exec_strb_nop", 32'(strb1), 32'(5'b00001));
    stepClock();
    checkOutput("inv_halt_state", 32'({halted0, pc0, carry0}), 32'({1'b1, 4'h7, 1'b1}));
    checkOutput("inv_nop_state", 32'({halted1, pc1, carry1}), 32'({1'b0, 4'h8, 1'b0}));
    for (int i = 0; i < 20; i++) begin
      applyStimulus(ADD_A_IMM, 4'h1, 1'b1, 1'b1);
      checkOutput($sformatf("halt_hold%0d", i), 32'({halted0, pc0, strb0}),
                  32'({1'b1, 4'h7, 5'b00000}));
      stepClock();
    end

    // Only reset leaves HALT.
    rst_n = 1'b0;
    #1;
    checkOutput("halt_reset", 32'({halted0, pc0, carry0}), 32'({1'b0, 4'h3, 1'b0}));
    rst_n = 1'b1;
    runInstr("after_halt", NOP, 4'h0, 1'b0, 4'h3, 2'd0, 5'b00001);

`ifdef TD4_SINGLE_STEP_EN
    // The first instruction after reset runs without a step. The next one
    // needs a step, after a pause held for 10 ticks.
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    applyStimulus(NOP, 4'h0, 1'b1, 1'b0);
    stepClock();
    applyStimulus(NOP, 4'h0, 1'b1, 1'b0);
    stepClock();
    applyStimulus(NOP, 4'h0, 1'b1, 1'b0);
    checkOutput("ss_first_done", 32'(instrDone0), 1);
    stepClock();
    resumeFromPause("ss_hold", 10);
    runInstr("ss_next", NOP, 4'h0, 1'b0, 4'h4, 2'd0, 5'b00001);
    checkOutput("ss_pc", 32'(pc0), 32'h5);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
